// File: rtl/scene_renderer.sv
// Samples the square/player descriptors once per frame and draws them on a 640x480 VGA raster in RGB332.
// Colour and sync trail the raster counters by 2 pixel ticks; define SQ_OUTLINE_EN to draw square borders in white.
module scene_renderer #(
  parameter int unsigned PIX_DIV  = 4,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter logic [2:0]  BG_IDX   = 3'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [40:0] square1,
  input  logic [40:0] square2,
  input  logic [40:0] square3,
  input  logic [23:0] player,
  output logic [2:0]  vga_r,
  output logic [2:0]  vga_g,
  output logic [1:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } shade_t;

  function automatic logic [8:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[8] ? (~d + 9'd1) : d;
  endfunction

  function automatic shade_t shade_sq(input logic [40:0] sq, input logic [7:0] lx,
                                      input logic [7:0] ly);
    logic [7:0] cx, cy, w, h;
    logic [8:0] col, dx, dy;
    shade_t     s;
    {cx, cy, w, h, col} = sq;
    dx    = abs_diff(lx, cx);
    dy    = abs_diff(ly, cy);
    s.hit = (w != 8'd0) && (dx <= {1'b0, w}) && (dy <= {1'b0, h});
    if (ly < cy)      s.idx = col[8:6];
    else if (lx < cx) s.idx = col[5:3];
    else              s.idx = col[2:0];
`ifdef SQ_OUTLINE_EN
    if ((dx == {1'b0, w}) || (dy == {1'b0, h})) s.idx = 3'd7;
`endif
    return s;
  endfunction

  // Player spans two columns {PX-1, PX} and rows [PY-PH, PY]; lower bounds saturate at 0.
  function automatic logic player_hit(input logic [23:0] p, input logic [7:0] lx,
                                      input logic [7:0] ly);
    logic [7:0] px, py, ph, x_lo, y_lo;
    {px, py, ph} = p;
    x_lo = (px == 8'd0) ? 8'd0 : px - 8'd1;
    y_lo = (py >= ph) ? py - ph : 8'd0;
    return (ph != 8'd0) && (lx >= x_lo) && (lx <= px) && (ly >= y_lo) && (ly <= py);
  endfunction

  function automatic logic [7:0] palette(input logic [2:0] idx);
    case (idx)
      3'd0:    return 8'b000_000_00;
      3'd1:    return 8'b111_000_00;
      3'd2:    return 8'b000_111_00;
      3'd3:    return 8'b000_000_11;
      3'd4:    return 8'b111_111_00;
      3'd5:    return 8'b000_111_11;
      3'd6:    return 8'b100_100_10;
      default: return 8'b111_111_11;
    endcase
  endfunction

  logic [DIV_W-1:0] div;
  logic             tick;
  logic [9:0]       hcount, vcount;
  logic             sample_now;
  logic [40:0]      sq1_q, sq2_q, sq3_q;
  logic [23:0]      pl_q;

  assign tick       = (div == DIV_LAST);
  assign sample_now = tick && (hcount == 10'd0) && (vcount == V_VIS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div    <= '0;
      hcount <= '0;
      vcount <= '0;
    end else begin
      div <= tick ? '0 : div + 1'b1;
      if (tick) begin
        if (hcount == H_LAST) begin
          hcount <= '0;
          vcount <= (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
        end else begin
          hcount <= hcount + 10'd1;
        end
      end
    end
  end

  // Descriptors are captured only at the start of vertical blanking, so a frame never tears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq1_q       <= '0;
      sq2_q       <= '0;
      sq3_q       <= '0;
      pl_q        <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= sample_now;
      if (sample_now) begin
        sq1_q <= square1;
        sq2_q <= square2;
        sq3_q <= square3;
        pl_q  <= player;
      end
    end
  end

  logic [7:0] lx, ly;
  shade_t     sh1, sh2, sh3;
  logic       pl_hit;

  assign lx = hcount[9:2];
  assign ly = {1'b0, vcount[8:2]};

  always_comb begin
    sh1    = shade_sq(sq1_q, lx, ly);
    sh2    = shade_sq(sq2_q, lx, ly);
    sh3    = shade_sq(sq3_q, lx, ly);
    pl_hit = player_hit(pl_q, lx, ly);
  end

  shade_t     s1_sq1, s1_sq2, s1_sq3;
  logic       s1_pl;
  logic [9:0] s1_h, s1_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_sq1 <= '0;
      s1_sq2 <= '0;
      s1_sq3 <= '0;
      s1_pl  <= 1'b0;
      s1_h   <= '0;
      s1_v   <= '0;
    end else if (tick) begin
      s1_sq1 <= sh1;
      s1_sq2 <= sh2;
      s1_sq3 <= sh3;
      s1_pl  <= pl_hit;
      s1_h   <= hcount;
      s1_v   <= vcount;
    end
  end

  logic [2:0] sel_idx;
  logic [7:0] rgb;
  logic       hs, vs;

  always_comb begin
    sel_idx = BG_IDX;
    if (s1_pl)           sel_idx = 3'd7;
    else if (s1_sq1.hit) sel_idx = s1_sq1.idx;
    else if (s1_sq2.hit) sel_idx = s1_sq2.idx;
    else if (s1_sq3.hit) sel_idx = s1_sq3.idx;
    rgb = palette(sel_idx);
    if ((s1_h >= H_VIS) || (s1_v >= V_VIS)) rgb = 8'd0;
    hs = !((s1_h >= HS_START) && (s1_h < HS_END));
    vs = !((s1_v >= VS_START) && (s1_v < VS_END));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {vga_r, vga_g, vga_b} <= 8'd0;
      vga_hs                <= 1'b1;
      vga_vs                <= 1'b1;
    end else if (tick) begin
      {vga_r, vga_g, vga_b} <= rgb;
      vga_hs                <= hs;
      vga_vs                <= vs;
    end
  end

endmodule
